// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU op codes, RV32M funct3 codes, mul/div FSM states and default width.
package ex_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLL    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_SLT    = 4'd8;
    localparam logic [3:0] ALU_SLTU   = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;
    localparam logic [2:0] MD_MUL     = 3'd0;
    localparam logic [2:0] MD_MULH    = 3'd1;
    localparam logic [2:0] MD_MULHSU  = 3'd2;
    localparam logic [2:0] MD_MULHU   = 3'd3;
    localparam logic [2:0] MD_DIV     = 3'd4;
    localparam logic [2:0] MD_DIVU    = 3'd5;
    localparam logic [2:0] MD_REM     = 3'd6;
    localparam logic [2:0] MD_REMU    = 3'd7;
    typedef enum logic {IDLE, BUSY} md_state_e;
endpackage

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: iterative radix-2 RV32M engine (shift-add multiply, restoring divide on magnitudes).
// Ports: clk/reset (sync, active-high); start_i launches an op from a_i/b_i/funct3_i/rd_i;
// busy_o = BUSY state, last_o = final step this cycle; result_o = final result when busy_o&last_o,
// otherwise the special-case value of the current inputs; rd_o = latched rd; early_o = inputs are a
// special case that may bypass BUSY (only when EX_MD_EARLY_EN is defined).
module ex_muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [XLEN-1:0]       a_i,
    input  logic [XLEN-1:0]       b_i,
    input  logic [2:0]            funct3_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic                  busy_o,
    output logic                  last_o,
    output logic                  early_o,
    output logic [XLEN-1:0]       result_o,
    output logic [REG_ADDR_W-1:0] rd_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    md_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2*XLEN-1:0]     p_q, p_d;
    logic [XLEN-1:0]       m_q, m_d, spec_val_q, spec_val_d, spec_val;
    logic [2:0]            f3_q, f3_d;
    logic                  neg_q, neg_d, spec_q, spec_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  sa, sb, div0, ovf, special;
    logic [XLEN-1:0]       ua, ub, q_fix, r_fix, fin;
    logic [XLEN:0]         add_s, rem_s, dif;
    logic [2*XLEN-1:0]     mul_n, div_n, prod;
    assign sa      = a_i[XLEN-1] & (funct3_i inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    assign sb      = b_i[XLEN-1] & (funct3_i inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
    assign ua      = sa ? -a_i : a_i;
    assign ub      = sb ? -b_i : b_i;
    assign div0    = funct3_i[2] & (b_i == '0);
    assign ovf     = (funct3_i inside {MD_DIV, MD_REM}) & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&b_i);
    assign special = div0 | ovf;
    // Division by zero and signed overflow give architecturally fixed values; the iterative
    // datapath result is overridden by these at the end.
    assign spec_val = div0 ? (funct3_i[1] ? a_i : '1) : (funct3_i[1] ? '0 : a_i);
`ifdef EX_MD_EARLY_EN
    assign early_o = special;
`else
    assign early_o = 1'b0;
`endif
    // Multiply: low half holds the multiplier, shifted out LSB-first while partial sums enter the top.
    assign add_s = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
    assign mul_n = {add_s, p_q[XLEN-1:1]};
    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    assign rem_s = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    assign dif   = rem_s - {1'b0, m_q};
    assign div_n = dif[XLEN] ? {rem_s[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                             : {dif[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    assign busy_o = state_q == BUSY;
    assign last_o = busy_o & (cnt_q == LAST);
    assign rd_o   = rd_q;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        m_d        = m_q;
        f3_d       = f3_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        rd_d       = rd_q;
        if (state_q == IDLE) begin
            if (start_i) begin
                state_d    = BUSY;
                cnt_d      = '0;
                p_d        = {{XLEN{1'b0}}, funct3_i[2] ? ua : ub};
                m_d        = funct3_i[2] ? ub : ua;
                f3_d       = funct3_i;
                neg_d      = (funct3_i == MD_REM) ? sa : sa ^ sb;
                spec_d     = special;
                spec_val_d = spec_val;
                rd_d       = rd_i;
            end
        end else begin
            p_d     = f3_q[2] ? div_n : mul_n;
            cnt_d   = last_o ? '0 : cnt_q + 1'b1;
            state_d = last_o ? IDLE : BUSY;
        end
    end
    // Sign fixup is applied to the value produced by the final step, so the result is ready at that edge.
    always_comb begin
        prod     = neg_q ? -p_d : p_d;
        q_fix    = neg_q ? -p_d[XLEN-1:0] : p_d[XLEN-1:0];
        r_fix    = neg_q ? -p_d[2*XLEN-1:XLEN] : p_d[2*XLEN-1:XLEN];
        fin      = spec_q ? spec_val_q
                 : f3_q[2] ? (f3_q[1] ? r_fix : q_fix)
                 : (f3_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        result_o = busy_o ? fin : spec_val;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        p_q        <= p_d;
        m_q        <= m_d;
        f3_q       <= f3_d;
        neg_q      <= neg_d;
        spec_q     <= spec_d;
        spec_val_q <= spec_val_d;
        rd_q       <= rd_d;
    end
endmodule

// File: rtl/ex_stage_muldiv.sv
// ex_stage_muldiv: execute stage with single-cycle ALU and iterative RV32M engine, registered EX/MEM output.
// Ports: clk/reset (sync, active-high); in_valid/alu_ctrl/is_md/md_funct3/op_a/op_b/rd_in from ID/EX;
// stall (combinational) freezes IF/ID and ID/EX; out_valid/result/rd_out registered toward MEM;
// md_busy = engine in BUSY. Optional macro EX_MD_EARLY_EN lets div-by-zero and signed overflow
// complete in one cycle instead of the fixed iterative latency.
module ex_stage_muldiv
    import ex_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [3:0]            alu_ctrl,
    input  logic                  is_md,
    input  logic [2:0]            md_funct3,
    input  logic [XLEN-1:0]       op_a,
    input  logic [XLEN-1:0]       op_b,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  stall,
    output logic                  out_valid,
    output logic [XLEN-1:0]       result,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  md_busy
);
    logic                  out_valid_q;
    logic [XLEN-1:0]       result_q, alu_res, md_res;
    logic [REG_ADDR_W-1:0] rd_q, md_rd;
    logic                  busy, last, early, launch;
    logic [4:0]            shamt;
    assign launch = in_valid & is_md & ~busy;
    assign shamt  = op_b[4:0];
    ex_muldiv_iter #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_md (
        .clk      (clk),
        .reset    (reset),
        .start_i  (launch & ~early),
        .a_i      (op_a),
        .b_i      (op_b),
        .funct3_i (md_funct3),
        .rd_i     (rd_in),
        .busy_o   (busy),
        .last_o   (last),
        .early_o  (early),
        .result_o (md_res),
        .rd_o     (md_rd)
    );
    // Stall releases during the final step so ID/EX advances on the same edge the result is written.
    assign stall     = ~reset & ((launch & ~early) | (busy & ~last));
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rd_out    = rd_q;
    assign md_busy   = busy;
    always_comb begin
        case (alu_ctrl)
            ALU_ADD:    alu_res = op_a + op_b;
            ALU_SUB:    alu_res = op_a - op_b;
            ALU_AND:    alu_res = op_a & op_b;
            ALU_OR:     alu_res = op_a | op_b;
            ALU_XOR:    alu_res = op_a ^ op_b;
            ALU_SLL:    alu_res = op_a << shamt;
            ALU_SRL:    alu_res = op_a >> shamt;
            ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_PASS_B: alu_res = op_b;
            default:    alu_res = '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_q        <= '0;
        end else if (busy) begin
            out_valid_q <= last;
            if (last) begin
                result_q <= md_res;
                rd_q     <= md_rd;
            end
        end else if (launch) begin
            out_valid_q <= early;
            if (early) begin
                result_q <= md_res;
                rd_q     <= rd_in;
            end
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                result_q <= alu_res;
                rd_q     <= rd_in;
            end
        end
    end
endmodule
